ccta_pipe: RTL
==============

// Module: ccta_pipe
// PURPOSE
//  Parametrised, pipelined successor of the CCTA 3-operand adder. Takes operands
//  A/B/C with a per-transaction mode and returns a registered W+2-bit result.
//  Adds a running-accumulate mode, optional saturation, and valid/ready flow control.
//  Sits between the operand-select logic and the result bus.
// PARAMETERS
//  W    4  operand width in bits (>=2); result width is W+2
//  SAT  0  1 = accumulate mode saturates at all-ones; 0 = wrap modulo 2^(W+2)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    operand beat valid
//  in_ready   out  1    block can accept a beat this cycle
//  a          in   W    operand A
//  b          in   W    operand B
//  c          in   W    operand C
//  mode       in   2    00 A+B, 01 A+C, 10 A+B+C, 11 ACC+=A
//  clr        in   1    synchronous clear of the accumulator
//  out_valid  out  1    result valid
//  out_ready  in   1    downstream accepts result
//  q          out  W+2  result
//  ovf        out  1    accumulate overflowed (wrapped or clamped) on this result
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): s1_valid=0, out_valid=0, q=0, ovf=0, acc=0.
//    In-flight beats are discarded. in_ready=1 while the pipe is empty.
//  - Beat transfer: on the input side when in_valid&in_ready; on the output side
//    when out_valid&out_ready.
//  - Stage 1 registers a, b, c, and mode. Stage 2 computes and registers q/ovf.
//    Latency is 2 cycles from the input transfer to out_valid. Throughput is 1 beat/cycle.
//  - adv2 = !out_valid | out_ready.  adv1 = !s1_valid | adv2.  in_ready = adv1.
//    in_ready is combinational from out_ready.
//  - Stall: q, ovf, and out_valid hold while out_valid & !out_ready.
//    Stage 1 holds while it is full and adv2=0.
//  - Modes 00/01/10: zero-extend to W+2, add, ovf=0. No overflow is possible:
//    3*(2^W-1) < 2^(W+2).
//  - Mode 11: computed when the beat enters stage 2. sum = acc + zext(a), computed
//    one bit wide. ovf = carry out of bit W+1. With SAT=1 and ovf=1, result = all-ones.
//    Otherwise result = sum mod 2^(W+2). acc <= result and q <= result.
//  - acc changes only on mode-11 stage-2 loads, clr, or reset.
//  - clr alone (no mode-11 load that cycle): acc <= 0 at the next edge.
//  - clr in the same cycle as a mode-11 stage-2 load: clear is applied first, so
//    acc <= zext(a), q <= zext(a), ovf=0.
//  - clr does not affect beats in flight in modes 00/01/10.
//  - Back-to-back mode-11 beats chain correctly: each beat uses the acc left by the
//    previous beat, with no bubble.
//  - Input fields are don't-care when in_valid=0.
//  - mode/a/b/c changes while in_ready=0 are ignored.
// STRUCTURE
//  - Shared package ccta_pkg holds:
//    - localparams MODE_AB=2'b00, MODE_AC=2'b01, MODE_ABC=2'b10, MODE_ACC=2'b11
//    - typedef ccta_mode_t
//  - One sub-module, ccta_acc_unit: the acc register, clr priority, wrap/saturate,
//    and ovf generation. ccta_pipe owns the handshake and stage registers.
//  - Target size is roughly 150-250 lines of RTL in total.
// TESTING (W=4)
//  1. Reset mid-stream. Drive beats, assert rst_n=0 between edges.
//     -> q=0, ovf=0, out_valid=0 immediately. acc=0. The first post-reset ACC beat
//        a=3 gives q=3.
//  2. Modes, out_ready=1. a=F,b=F,c=F:
//     - mode 00 -> q=1E
//     - mode 01 -> q=1E
//     - mode 10 -> q=2D
//     Each arrives 2 cycles after its input transfer, with ovf=0.
//  3. Accumulate wrap, SAT=0. Six ACC beats of a=F, then a=4.
//     -> q = 0F,1E,2D,3C,0B(ovf=1),1A,1E. Wrap at 3C+F=4B.
//  4. Saturate, SAT=1, same stimulus as test 3.
//     -> 0F,1E,2D,3C,3F(ovf=1),3F(ovf=1),3F(ovf=1).
//  5. clr priority. acc=2D, then an ACC beat a=5 with clr high on its stage-2 load.
//     -> q=05, ovf=0. A following ACC beat a=1 -> q=06.
//  6. Backpressure. Hold out_ready=0 for 5 cycles with in_valid=1.
//     -> Two beats are accepted, then in_ready=0 and q holds.
//     -> On release, results drain in order with no loss or duplication.

Source files
------------

// File: rtl/ccta_pkg.sv
// Shared definitions for the CCTA pipelined adder: operation modes and their encoding.
package ccta_pkg;

    typedef logic [1:0] ccta_mode_t;

    localparam ccta_mode_t MODE_AB  = 2'b00;
    localparam ccta_mode_t MODE_AC  = 2'b01;
    localparam ccta_mode_t MODE_ABC = 2'b10;
    localparam ccta_mode_t MODE_ACC = 2'b11;

endpackage : ccta_pkg

// File: rtl/ccta_acc_unit.sv
// Running accumulator for the CCTA pipe: clear priority, wrap/saturate and overflow flag.
// result/ovf are the combinational outcome of a load this cycle; acc updates on load or clr.
module ccta_acc_unit #(
    parameter int W   = 4,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] a,
    output logic [W+1:0] result,
    output logic         ovf
);

    localparam bit SAT_EN = (SAT != 0);

    logic [W+1:0] acc;
    logic [W+1:0] base;
    logic [W+2:0] sum;

    // A clear in the same cycle as a load acts first, so the load starts from zero.
    assign base = clr ? '0 : acc;
    assign sum  = {1'b0, base} + {3'b000, a};
    assign ovf  = sum[W+2];

    always_comb begin
        result = sum[W+1:0];
        if (SAT_EN && ovf) begin
            result = '1;
        end
    end

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= result;
        end else if (clr) begin
            acc <= '0;
        end
    end

endmodule : ccta_acc_unit

// File: rtl/ccta_pipe.sv
// Two-stage pipelined 3-operand adder with accumulate mode and valid/ready flow control.
// Stage 1 registers the operands, stage 2 registers the result; 1 beat/cycle throughput.
module ccta_pipe #(
    parameter int W   = 4,
    parameter int SAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [1:0]   mode,
    input  logic         clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+1:0] q,
    output logic         ovf
);

    import ccta_pkg::*;

    logic         adv1;
    logic         adv2;
    logic         s1_valid;
    logic [W-1:0] s1_a;
    logic [W-1:0] s1_b;
    logic [W-1:0] s1_c;
    ccta_mode_t   s1_mode;

    logic         acc_load;
    logic [W+1:0] acc_result;
    logic         acc_ovf;
    logic [W+1:0] q_d;
    logic         ovf_d;

    // Stage 2 moves when its output is empty or being taken; stage 1 when it can hand off.
    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: operand payload has no reset; s1_valid alone decides whether it means anything.
    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            s1_a    <= a;
            s1_b    <= b;
            s1_c    <= c;
            s1_mode <= mode;
        end
    end

    assign acc_load = s1_valid && adv2 && (s1_mode == MODE_ACC);

    ccta_acc_unit #(
        .W   (W),
        .SAT (SAT)
    ) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (acc_load),
        .clr    (clr),
        .a      (s1_a),
        .result (acc_result),
        .ovf    (acc_ovf)
    );

    // NOTE: defaults first so every path assigns q_d/ovf_d and no latch is inferred.
    always_comb begin
        q_d   = '0;
        ovf_d = 1'b0;
        case (s1_mode)
            MODE_AB:  q_d = {2'b00, s1_a} + {2'b00, s1_b};
            MODE_AC:  q_d = {2'b00, s1_a} + {2'b00, s1_c};
            MODE_ABC: q_d = {2'b00, s1_a} + {2'b00, s1_b} + {2'b00, s1_c};
            MODE_ACC: begin
                q_d   = acc_result;
                ovf_d = acc_ovf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            q         <= '0;
            ovf       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                q   <= q_d;
                ovf <= ovf_d;
            end
        end
    end

endmodule : ccta_pipe
